// File: rtl/carry_resolve_seq.sv
// Carry-propagate stage: captures one redundant (carry, sum) result and streams
// the resolved radix-2^RADIX_W digits out LANES per beat, least significant beat first.
module carry_resolve_seq #(
    parameter int NUM_DIGITS = 130,
    parameter int DIGIT_W    = 19,
    parameter int RADIX_W    = 16,
    parameter int LANES      = 10
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   in_c,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   in_s,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES-1:0][RADIX_W-1:0]        out_digits,
    output logic [3:0]                           out_beat,
    output logic                                 out_last,
    output logic [4:0]                           out_carry
);

    localparam int NUM_BEATS = NUM_DIGITS / LANES;
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int SUM_W     = DIGIT_W + 2;
    localparam int CARRY_W   = 5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                              state_reg, state_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  c_reg, s_reg;
    logic [CARRY_W-1:0]                  carry_reg;
    logic [3:0]                          beat_idx_reg;
    logic                                out_valid_reg, out_last_reg;
    logic [LANES-1:0][RADIX_W-1:0]       out_digits_reg;
    logic [3:0]                          out_beat_reg;
    logic [CARRY_W-1:0]                  out_carry_reg;

    logic                                capture, load, last_hs;
    logic                                beat_is_last;
    logic [IDX_W-1:0]                    base_idx;
    logic [LANES:0][CARRY_W-1:0]         cin;
    logic [LANES-1:0][RADIX_W-1:0]       beat_digits;

    assign base_idx     = IDX_W'(beat_idx_reg) * IDX_W'(LANES);
    assign beat_is_last = (beat_idx_reg == 4'(NUM_BEATS - 1));
    assign cin[0]       = carry_reg;

    // Lane ripple: 2*(2^19-1)+16 fits in 21 bits, so the carry never exceeds 16.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IDX_W-1:0] idx;
        logic [SUM_W-1:0] sum_w;
        assign idx             = base_idx + IDX_W'(gi);
        assign sum_w           = SUM_W'(c_reg[idx]) + SUM_W'(s_reg[idx]) + SUM_W'(cin[gi]);
        assign beat_digits[gi] = sum_w[RADIX_W-1:0];
        assign cin[gi+1]       = sum_w[RADIX_W +: CARRY_W];
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        load       = 1'b0;
        last_hs    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (out_valid_reg && out_ready && out_last_reg) begin
                    last_hs    = 1'b1;
                    state_next = IDLE;
                end else if (!out_valid_reg || out_ready) begin
                    load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand storage carries no reset; it is only read while in RUN after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            c_reg <= in_c;
            s_reg <= in_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg    <= '0;
            beat_idx_reg <= '0;
        end else if (capture) begin
            carry_reg    <= '0;
            beat_idx_reg <= '0;
        end else if (load) begin
            carry_reg    <= cin[LANES];
            beat_idx_reg <= beat_idx_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_digits_reg <= '0;
            out_beat_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_carry_reg  <= '0;
        end else if (load) begin
            out_valid_reg  <= 1'b1;
            out_digits_reg <= beat_digits;
            out_beat_reg   <= beat_idx_reg;
            out_last_reg   <= beat_is_last;
            out_carry_reg  <= beat_is_last ? cin[LANES] : '0;
        end else if (last_hs) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = out_valid_reg;
    assign out_digits = out_digits_reg;
    assign out_beat   = out_beat_reg;
    assign out_last   = out_last_reg;
    assign out_carry  = out_carry_reg;

endmodule
